// File: rtl/mtl_pkg.sv
// rtl/mtl_pkg.sv - shared types and panel constants for the MTL frame prefetcher
package mtl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST
  } pf_state_t;

  localparam int unsigned H_ACTIVE = 800;
  localparam int unsigned V_ACTIVE = 480;

  typedef logic [31:0] pixel_t;

endpackage

// File: rtl/mtl_frame_prefetch_if.sv
// rtl/mtl_frame_prefetch_if.sv - SDRAM burst-read port between prefetcher and memory controller
interface mtl_frame_prefetch_if
  import mtl_pkg::*;
#(
  parameter int unsigned ADDR_W = 23
);

  logic              oRD_REQ;
  logic [ADDR_W-1:0] oRD_ADDR;
  logic              iRD_GNT;
  logic              iRD_VALID;
  pixel_t            iRD_DATA;

  modport master (
    output oRD_REQ,
    output oRD_ADDR,
    input  iRD_GNT,
    input  iRD_VALID,
    input  iRD_DATA
  );

  modport slave (
    input  oRD_REQ,
    input  oRD_ADDR,
    output iRD_GNT,
    output iRD_VALID,
    output iRD_DATA
  );

endinterface

// File: rtl/mtl_sync_fifo.sv
// rtl/mtl_sync_fifo.sv - single-clock word FIFO with synchronous clear and occupancy count
module mtl_sync_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Clear has priority so a flush on the same edge as a push/pop leaves the FIFO empty.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/mtl_frame_prefetch.sv
// rtl/mtl_frame_prefetch.sv - burst-reads the current frame from SDRAM ahead of the LCD pixel reads
module mtl_frame_prefetch
  import mtl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned BURST_LEN   = 64,
  parameter int unsigned FRAME_WORDS = H_ACTIVE * V_ACTIVE
) (
  input  logic                 iCLK,
  input  logic                 iRST_n,
  input  logic                 iNEW_FRAME,
  input  logic [ADDR_W-1:0]    iFRAME_BASE,
  input  logic                 iREAD_EN,
  output pixel_t               oREAD_DATA,
  output logic                 oUNDERFLOW,
  mtl_frame_prefetch_if.master rd_bus
);

  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FETCH_W = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BEAT_W  = $clog2(BURST_LEN);

  if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_chk_frame
    $error("FRAME_WORDS must be a multiple of BURST_LEN");
  end
  if (FIFO_DEPTH < 2 * BURST_LEN) begin : g_chk_depth
    $error("FIFO_DEPTH must be at least 2*BURST_LEN");
  end
  if (((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || ((BURST_LEN & (BURST_LEN - 1)) != 0)) begin : g_chk_pow2
    $error("FIFO_DEPTH and BURST_LEN must be powers of two");
  end

  pf_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  pend_base_q, pend_base_d;
  logic [FETCH_W-1:0] fetched_q, fetched_d;
  logic [BEAT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]   reserve_q, reserve_d;
  logic               flush_pend_q, flush_pend_d;
  logic               armed_q, armed_d;
  logic               underflow_q, underflow_d;
  pixel_t             rdata_q, rdata_d;

  logic               fifo_push, fifo_pop, fifo_clear;
  logic               fifo_empty, fifo_full;
  pixel_t             fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;
  logic [CNT_W-1:0]   free_words;
  logic               last_beat;
  logic               flush_now;

  mtl_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (iCLK),
    .rst_ni  (iRST_n),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .wdata_i (rd_bus.iRD_DATA),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Reserve covers beats granted but not yet written, so a new request never oversubscribes the FIFO.
  assign free_words = CNT_W'(FIFO_DEPTH) - fifo_count - reserve_q;
  assign last_beat  = (state_q == BURST) && rd_bus.iRD_VALID && (beat_q == BEAT_W'(BURST_LEN - 1));
  assign flush_now  = ((state_q == IDLE) && iNEW_FRAME) ||
                      (last_beat && (flush_pend_q || iNEW_FRAME));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pend_base_d  = pend_base_q;
    fetched_d    = fetched_q;
    beat_d       = beat_q;
    reserve_d    = reserve_q;
    flush_pend_d = flush_pend_q;
    armed_d      = armed_q;
    underflow_d  = underflow_q;
    rdata_d      = rdata_q;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_clear   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!iNEW_FRAME && armed_q && (fetched_q < FETCH_W'(FRAME_WORDS)) &&
            (free_words >= CNT_W'(BURST_LEN))) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (rd_bus.iRD_GNT) begin
          state_d   = BURST;
          beat_d    = '0;
          reserve_d = CNT_W'(BURST_LEN);
        end
      end
      BURST: begin
        if (rd_bus.iRD_VALID) begin
          beat_d    = beat_q + BEAT_W'(1);
          reserve_d = reserve_q - CNT_W'(1);
          fifo_push = !flush_pend_q;
          if (last_beat) begin
            state_d   = IDLE;
            addr_d    = addr_q + ADDR_W'(BURST_LEN);
            fetched_d = fetched_q + FETCH_W'(BURST_LEN);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && iNEW_FRAME) begin
      flush_pend_d = 1'b1;
      pend_base_d  = iFRAME_BASE;
    end

    // A read coinciding with the frame pulse returns zero without popping or flagging.
    if (iREAD_EN) begin
      if (iNEW_FRAME) begin
        rdata_d = '0;
      end else if (!fifo_empty) begin
        fifo_pop = 1'b1;
        rdata_d  = fifo_rdata;
      end else begin
        rdata_d     = '0;
        underflow_d = 1'b1;
      end
    end

    if (flush_now) begin
      fifo_clear   = 1'b1;
      flush_pend_d = 1'b0;
      addr_d       = iNEW_FRAME ? iFRAME_BASE : pend_base_q;
      fetched_d    = '0;
      underflow_d  = 1'b0;
      armed_d      = 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      pend_base_q  <= '0;
      fetched_q    <= '0;
      beat_q       <= '0;
      reserve_q    <= '0;
      flush_pend_q <= 1'b0;
      armed_q      <= 1'b0;
      underflow_q  <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pend_base_q  <= pend_base_d;
      fetched_q    <= fetched_d;
      beat_q       <= beat_d;
      reserve_q    <= reserve_d;
      flush_pend_q <= flush_pend_d;
      armed_q      <= armed_d;
      underflow_q  <= underflow_d;
      rdata_q      <= rdata_d;
    end
  end

  assign rd_bus.oRD_REQ  = (state_q == REQ);
  assign rd_bus.oRD_ADDR = addr_q;
  assign oREAD_DATA      = rdata_q;
  assign oUNDERFLOW      = underflow_q;

  a_no_overflow: assert property (@(posedge iCLK) disable iff (!iRST_n)
    !(fifo_push && fifo_full && !fifo_clear));

endmodule

// File: tb/tb_mtl_frame_prefetch.sv
// tb/tb_mtl_frame_prefetch.sv - directed self-checking bench for the MTL frame prefetcher
module tb_mtl_frame_prefetch;

  localparam int ADDR_W = 23;
  localparam int FRAME  = 3072;

  logic              clk;
  logic              rst_n;
  logic              new_frame;
  logic [ADDR_W-1:0] frame_base;
  logic              read_en;
  logic [31:0]       rdata;
  logic              underflow;

  int          n_tests, n_fail;
  int          nreq, ms, wcnt, beat_idx;
  logic [22:0] baddr;
  logic [22:0] req_addr [1024];

  int          n0, errs, k_iss, k_chk, cyc;
  logic        prev;
  logic [31:0] d;

  mtl_frame_prefetch_if #(.ADDR_W(ADDR_W)) rd_bus ();

  mtl_frame_prefetch #(
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (512),
    .BURST_LEN   (64),
    .FRAME_WORDS (FRAME)
  ) dut (
    .iCLK        (clk),
    .iRST_n      (rst_n),
    .iNEW_FRAME  (new_frame),
    .iFRAME_BASE (frame_base),
    .iREAD_EN    (read_en),
    .oREAD_DATA  (rdata),
    .oUNDERFLOW  (underflow),
    .rd_bus      (rd_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // SDRAM model: grant 3 cycles after request, then 64 back-to-back beats with data = address.
  initial begin
    rd_bus.iRD_GNT   = 1'b0;
    rd_bus.iRD_VALID = 1'b0;
    rd_bus.iRD_DATA  = '0;
    ms = 0; wcnt = 0; beat_idx = 0; nreq = 0; baddr = '0;
    forever begin
      @(negedge clk);
      rd_bus.iRD_GNT   = 1'b0;
      rd_bus.iRD_VALID = 1'b0;
      if (!rst_n) begin
        ms = 0;
        beat_idx = 0;
      end else begin
        case (ms)
          0: begin
            beat_idx = 0;
            if (rd_bus.oRD_REQ) begin
              wcnt = 3;
              ms = 1;
            end
          end
          1: begin
            wcnt--;
            if (wcnt == 0) begin
              rd_bus.iRD_GNT = 1'b1;
              baddr = rd_bus.oRD_ADDR;
              if (nreq < 1024) req_addr[nreq] = baddr;
              nreq++;
              ms = 2;
            end
          end
          default: begin
            rd_bus.iRD_VALID = 1'b1;
            rd_bus.iRD_DATA  = {9'h0, baddr + 23'(beat_idx)};
            beat_idx++;
            if (beat_idx == 64) ms = 0;
          end
        endcase
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pulse_frame(input logic [22:0] base, input logic with_read);
    @(negedge clk);
    new_frame  = 1'b1;
    frame_base = base;
    read_en    = with_read;
    @(negedge clk);
    new_frame  = 1'b0;
    read_en    = 1'b0;
  endtask

  task automatic read_one(output logic [31:0] v);
    @(negedge clk);
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    v = rdata;
  endtask

  task automatic read_run(input int n, input logic [31:0] first, input string tag);
    int          bad;
    logic [31:0] exp;
    bad = 0;
    exp = first;
    @(negedge clk);
    read_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) read_en = 1'b0;
      if (rdata !== exp) bad++;
      exp = exp + 32'd1;
    end
    check_eq(tag, 32'(bad), 32'd0);
  endtask

  task automatic wait_beat(input int target, input int budget, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #2;
      n++;
    end while ((beat_idx != target) && (n < budget));
    check_eq(tag, 32'(beat_idx == target), 32'd1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; new_frame = 1'b0; frame_base = '0; read_en = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_underflow", 32'(underflow), 32'd0);
    check_eq("rst_req", 32'(rd_bus.oRD_REQ), 32'd0);
    check_eq("rst_addr", 32'(rd_bus.oRD_ADDR), 32'd0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("no_req_before_frame", 32'(nreq), 32'd0);

    // First frame fills the FIFO and stops requesting.
    pulse_frame(23'h000100, 1'b0);
    repeat (900) @(negedge clk);
    check_eq("fill_addr0", 32'(req_addr[0]), 32'h100);
    check_eq("fill_addr1", 32'(req_addr[1]), 32'h140);
    check_eq("fill_bursts", 32'(nreq), 32'd8);
    check_eq("fill_count", 32'(dut.fifo_count), 32'd512);
    check_eq("fill_req_idle", 32'(rd_bus.oRD_REQ), 32'd0);

    // Read on an empty FIFO straight after a flush.
    pulse_frame(23'h002000, 1'b0);
    check_eq("flush_uf_pre", 32'(underflow), 32'd0);
    read_one(d);
    check_eq("uf_rdata", d, 32'd0);
    check_eq("uf_flag", 32'(underflow), 32'd1);
    repeat (900) @(negedge clk);
    read_one(d);
    check_eq("uf_frame_word0", d, 32'h2000);
    check_eq("uf_sticky", 32'(underflow), 32'd1);

    // New frame together with a read: zero data, underflow cleared.
    pulse_frame(23'h010000, 1'b1);
    check_eq("nf_read_rdata", rdata, 32'd0);
    check_eq("nf_uf_cleared", 32'(underflow), 32'd0);
    n0 = nreq;
    repeat (700) @(negedge clk);
    check_eq("frame_addr0", 32'(req_addr[n0]), 32'h10000);

    // Whole frame read with a 2-of-3 read-enable cadence.
    k_iss = 0; k_chk = 0; prev = 1'b0; errs = 0; cyc = 0;
    while ((k_chk < FRAME) && (cyc < 20000)) begin
      @(negedge clk);
      if (prev) begin
        if (rdata !== (32'h10000 + 32'(k_chk))) errs++;
        k_chk++;
      end
      prev = ((cyc % 3) != 2) && (k_iss < FRAME);
      read_en = prev;
      if (prev) k_iss++;
      cyc++;
    end
    read_en = 1'b0;
    check_eq("frame_word_errs", 32'(errs), 32'd0);
    check_eq("frame_words", 32'(k_chk), 32'(FRAME));
    repeat (300) @(negedge clk);
    check_eq("frame_bursts", 32'(nreq - n0), 32'd48);
    check_eq("frame_underflow", 32'(underflow), 32'd0);
    check_eq("frame_end_req", 32'(rd_bus.oRD_REQ), 32'd0);

    // New frame at beat 20 of a burst.
    pulse_frame(23'h004000, 1'b0);
    n0 = nreq;
    wait_beat(20, 200, "b20_reached");
    new_frame  = 1'b1;
    frame_base = 23'h006000;
    @(negedge clk);
    new_frame  = 1'b0;
    repeat (900) @(negedge clk);
    check_eq("b20_old_addr", 32'(req_addr[n0]), 32'h4000);
    check_eq("b20_new_addr", 32'(req_addr[n0 + 1]), 32'h6000);
    read_one(d);
    check_eq("b20_first_word", d, 32'h6000);

    // Push and pop together at count 511.
    read_run(63, 32'h6001, "pp_pre_order");
    wait_beat(64, 300, "pp_reached");
    read_en = 1'b1;
    @(negedge clk);
    read_en = 1'b0;
    check_eq("pp_word", rdata, 32'h6040);
    check_eq("pp_count", 32'(dut.fifo_count), 32'd511);
    read_run(511, 32'h6041, "pp_order");

    // Asynchronous reset mid-burst.
    wait_beat(10, 300, "rst_reached");
    rst_n = 1'b0;
    #1;
    check_eq("arst_req", 32'(rd_bus.oRD_REQ), 32'd0);
    check_eq("arst_addr", 32'(rd_bus.oRD_ADDR), 32'd0);
    check_eq("arst_rdata", rdata, 32'd0);
    check_eq("arst_underflow", 32'(underflow), 32'd0);
    check_eq("arst_state", 32'(dut.state_q), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    n0 = nreq;
    repeat (300) @(negedge clk);
    check_eq("arst_no_req", 32'(nreq), 32'(n0));
    pulse_frame(23'h009000, 1'b0);
    repeat (20) @(negedge clk);
    check_eq("arst_new_bursts", 32'(nreq), 32'(n0 + 1));
    check_eq("arst_new_addr", 32'(req_addr[n0]), 32'h9000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
